mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences the shared ALU, the unified instruction/data memory port, the IR, PC and register file over several cycles per instruction.
- Decodes the 6-bit opcode using 6-input AND-style match terms.
- Sits between the IR opcode field and the datapath mux selects and write strobes; ALU function decode stays in the separate ALU decoder, which consumes aluop.

Parameters:
- None. Opcode encodings are fixed: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- op  input  6  opcode field from IR, bits 31:26
- mem_ready  input  1  memory port has completed the current access
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  output  1  memory write strobe
- irwrite  output  1  IR load enable
- pcwrite  output  1  unconditional PC load
- branch  output  1  conditional PC load; datapath ANDs it with zero
- pcsrc  output  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- regdst  output  1  write register: 0 = rt, 1 = rd
- memtoreg  output  1  register write data: 0 = ALUOut, 1 = MDR
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU A operand: 0 = PC, 1 = register A
- alusrcb  output  2  ALU B operand: 00 = register B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
- aluop  output  2  to ALU decoder: 00 = add, 01 = sub, 10 = use funct
- illegal_op  output  1  unrecognised opcode seen in DECODE
- state  output  4  current state encoding, for debug

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11. Encodings 12-15 are unused.
- Reset: when reset = 1 at a clk edge, state becomes FETCH; reset overrides every other input.
- Strobe gating: while reset is high, irwrite, pcwrite, memwrite, regwrite, branch and illegal_op are forced to 0.
- Output decode: outputs decode combinationally from state, plus mem_ready where noted. Any output not listed for a state is 0.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (precomputes the branch target). Next state from op: lw/sw → MEMADR; R-type → EXEC; beq → BRANCH; j → JUMP; addi → ADDIEX; anything else → FETCH with illegal_op=1 for that cycle.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next state: lw → MEMRD; sw → MEMWR.
- MEMRD: iord=1. Hold while mem_ready=0; go to MEMWB when mem_ready=1.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next state FETCH.
- MEMWR: iord=1, memwrite=1, held high until mem_ready=1. Next state FETCH on mem_ready=1.
- EXEC: alusrca=1, alusrcb=00, aluop=10. Next state ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Next state FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Next state FETCH.
- JUMP: pcsrc=10, pcwrite=1. Next state FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next state ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next state FETCH.
- Latency with mem_ready tied high, counted in cycles from FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each cycle of mem_ready=0 adds one cycle.
- op must be stable from DECODE until the instruction returns to FETCH; the IR guarantees this because irwrite is asserted only in FETCH.
- Unused encodings 12-15: next state FETCH, all strobes 0 (self-recovery).
- Reset mid-instruction: the instruction is abandoned with no strobe in the reset cycle. The next cycle is FETCH.

Optional Feature:
- Macro: MIPS_CTRL_ADDI_EN.
- Defined: addi (001000) follows DECODE → ADDIEX → ADDIWB → FETCH as above.
- Undefined: ADDIEX and ADDIWB are not built; 001000 is treated as illegal (DECODE → FETCH, illegal_op=1).

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 → state=0; irwrite=pcwrite=0 while reset is high, both =1 in the first cycle after release.
- lw (op=100011), mem_ready=1 → state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
- sw (op=101011), mem_ready=0 for 3 cycles in MEMWR → state 5 held for 4 cycles with memwrite=1 throughout, then state 0; regwrite never 1.
- R-type (000000) → states 0,1,6,7,0; aluop=10 in state 6, regdst=1 and regwrite=1 in state 7. beq (000100) → 0,1,8,0 with branch=1, aluop=01. j (000010) → 0,1,9,0 with pcsrc=10, pcwrite=1.
- op=111111 → states 0,1,0; illegal_op=1 only in DECODE; no write strobe. With MIPS_CTRL_ADDI_EN undefined, op=001000 behaves identically.
- With MIPS_CTRL_ADDI_EN defined, addi (001000) → 0,1,10,11,0; alusrcb=10 in state 10, regdst=0 and regwrite=1 in state 11. Reset asserted in state 10 → next state 0, no regwrite.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS main FSM and its datapath.
// master = controller (drives selects/strobes), slave = datapath (drives opcode and mem_ready).
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  op, mem_ready,
        output iord, memwrite, irwrite, pcwrite, branch, pcsrc, regdst, memtoreg,
               regwrite, alusrca, alusrcb, aluop, illegal_op, state
    );

    modport slave (
        output op, mem_ready,
        input  iord, memwrite, irwrite, pcwrite, branch, pcsrc, regdst, memtoreg,
               regwrite, alusrca, alusrcb, aluop, illegal_op, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Define MIPS_CTRL_ADDI_EN to build the addi path (ADDIEX/ADDIWB); otherwise addi is illegal.
module mips_multicycle_ctrl (
    input logic                  clk,
    input logic                  reset,
    mips_multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11
    } state_e;

    state_e state_q, state_d;

    logic is_rtype, is_lw, is_sw, is_beq, is_j, is_addi;
    logic iord, memwrite, irwrite, pcwrite, branch, regdst, memtoreg, regwrite;
    logic alusrca, illegal_op;
    logic [1:0] pcsrc, alusrcb, aluop;

    always_comb begin
        is_rtype = (bus.op == 6'b000000);
        is_lw    = (bus.op == 6'b100011);
        is_sw    = (bus.op == 6'b101011);
        is_beq   = (bus.op == 6'b000100);
        is_j     = (bus.op == 6'b000010);
`ifdef MIPS_CTRL_ADDI_EN
        is_addi  = (bus.op == 6'b001000);
`else
        is_addi  = 1'b0;
`endif
    end

    always_comb begin
        state_d    = StFetch;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        pcsrc      = 2'b00;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        illegal_op = 1'b0;
        case (state_q)
            StFetch: begin
                alusrcb = 2'b01;
                irwrite = bus.mem_ready;
                pcwrite = bus.mem_ready;
                state_d = bus.mem_ready ? StDecode : StFetch;
            end
            StDecode: begin
                // ALU precomputes PC + (imm << 2) for a possible branch
                alusrcb = 2'b11;
                if (is_lw || is_sw)  state_d = StMemAdr;
                else if (is_rtype)   state_d = StExec;
                else if (is_beq)     state_d = StBranch;
                else if (is_j)       state_d = StJump;
                else if (is_addi)    state_d = StAddiEx;
                else                 illegal_op = 1'b1;
            end
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (is_lw)      state_d = StMemRd;
                else if (is_sw) state_d = StMemWr;
            end
            StMemRd: begin
                iord    = 1'b1;
                state_d = bus.mem_ready ? StMemWb : StMemRd;
            end
            StMemWb: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            StMemWr: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                state_d  = bus.mem_ready ? StFetch : StMemWr;
            end
            StExec: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = StAluWb;
            end
            StAluWb: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            StBranch: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            StJump: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
`ifdef MIPS_CTRL_ADDI_EN
            StAddiEx: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = StAddiWb;
            end
            StAddiWb: begin
                regwrite = 1'b1;
            end
`endif
            default: state_d = StFetch;
        endcase

        // Reset abandons the instruction without side effects in the reset cycle
        if (reset) begin
            irwrite    = 1'b0;
            pcwrite    = 1'b0;
            memwrite   = 1'b0;
            regwrite   = 1'b0;
            branch     = 1'b0;
            illegal_op = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= StFetch;
        else       state_q <= state_d;
    end

    assign bus.iord       = iord;
    assign bus.memwrite   = memwrite;
    assign bus.irwrite    = irwrite;
    assign bus.pcwrite    = pcwrite;
    assign bus.branch     = branch;
    assign bus.pcsrc      = pcsrc;
    assign bus.regdst     = regdst;
    assign bus.memtoreg   = memtoreg;
    assign bus.regwrite   = regwrite;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.aluop      = aluop;
    assign bus.illegal_op = illegal_op;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class through its states.
module tb_mips_multicycle_ctrl;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled just after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus.op = 6'b000000;

        // Reset held two cycles, strobes gated
        tick();
        check_eq("rst_state", 32'(bus.state), 0);
        check_eq("rst_irwrite", 32'(bus.irwrite), 0);
        check_eq("rst_pcwrite", 32'(bus.pcwrite), 0);
        tick();
        check_eq("rst_irwrite2", 32'(bus.irwrite), 0);
        reset = 1'b0;
        #1;
        check_eq("rel_state", 32'(bus.state), 0);
        check_eq("rel_irwrite", 32'(bus.irwrite), 1);
        check_eq("rel_pcwrite", 32'(bus.pcwrite), 1);

        // FETCH stalls while memory is busy
        bus.mem_ready = 1'b0;
        #1;
        check_eq("fetch_stall_irwrite", 32'(bus.irwrite), 0);
        tick();
        check_eq("fetch_stall_state", 32'(bus.state), 0);
        bus.mem_ready = 1'b1;

        // lw: 0,1,2,3,4,0
        bus.op = 6'b100011;
        tick();
        check_eq("lw_s1", 32'(bus.state), 1);
        check_eq("lw_s1_alusrcb", 32'(bus.alusrcb), 3);
        check_eq("lw_s1_illegal", 32'(bus.illegal_op), 0);
        tick();
        check_eq("lw_s2", 32'(bus.state), 2);
        check_eq("lw_s2_alusrcb", 32'(bus.alusrcb), 2);
        tick();
        check_eq("lw_s3", 32'(bus.state), 3);
        check_eq("lw_s3_iord", 32'(bus.iord), 1);
        check_eq("lw_s3_regwrite", 32'(bus.regwrite), 0);
        tick();
        check_eq("lw_s4", 32'(bus.state), 4);
        check_eq("lw_s4_regwrite", 32'(bus.regwrite), 1);
        check_eq("lw_s4_memtoreg", 32'(bus.memtoreg), 1);
        tick();
        check_eq("lw_s0", 32'(bus.state), 0);
        check_eq("lw_s0_regwrite", 32'(bus.regwrite), 0);

        // sw with three busy cycles in MEMWR
        bus.op = 6'b101011;
        tick();
        check_eq("sw_s1", 32'(bus.state), 1);
        tick();
        check_eq("sw_s2", 32'(bus.state), 2);
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = (i == 3);
            #1;
            check_eq("sw_s5", 32'(bus.state), 5);
            check_eq("sw_s5_memwrite", 32'(bus.memwrite), 1);
            check_eq("sw_s5_regwrite", 32'(bus.regwrite), 0);
            tick();
        end
        check_eq("sw_s0", 32'(bus.state), 0);
        check_eq("sw_s0_memwrite", 32'(bus.memwrite), 0);

        // R-type: 0,1,6,7,0
        bus.op = 6'b000000;
        tick();
        check_eq("r_s1", 32'(bus.state), 1);
        tick();
        check_eq("r_s6", 32'(bus.state), 6);
        check_eq("r_s6_aluop", 32'(bus.aluop), 2);
        check_eq("r_s6_alusrca", 32'(bus.alusrca), 1);
        tick();
        check_eq("r_s7", 32'(bus.state), 7);
        check_eq("r_s7_regdst", 32'(bus.regdst), 1);
        check_eq("r_s7_regwrite", 32'(bus.regwrite), 1);
        tick();
        check_eq("r_s0", 32'(bus.state), 0);

        // beq: 0,1,8,0
        bus.op = 6'b000100;
        tick();
        check_eq("beq_s1", 32'(bus.state), 1);
        tick();
        check_eq("beq_s8", 32'(bus.state), 8);
        check_eq("beq_s8_branch", 32'(bus.branch), 1);
        check_eq("beq_s8_aluop", 32'(bus.aluop), 1);
        check_eq("beq_s8_pcsrc", 32'(bus.pcsrc), 1);
        tick();
        check_eq("beq_s0", 32'(bus.state), 0);
        check_eq("beq_s0_branch", 32'(bus.branch), 0);

        // j: 0,1,9,0
        bus.op = 6'b000010;
        tick();
        check_eq("j_s1", 32'(bus.state), 1);
        tick();
        check_eq("j_s9", 32'(bus.state), 9);
        check_eq("j_s9_pcsrc", 32'(bus.pcsrc), 2);
        check_eq("j_s9_pcwrite", 32'(bus.pcwrite), 1);
        tick();
        check_eq("j_s0", 32'(bus.state), 0);

        // Unknown opcode: 0,1,0 with illegal_op only in DECODE
        bus.op = 6'b111111;
        tick();
        check_eq("ill_s1", 32'(bus.state), 1);
        check_eq("ill_s1_flag", 32'(bus.illegal_op), 1);
        check_eq("ill_s1_regwrite", 32'(bus.regwrite), 0);
        tick();
        check_eq("ill_s0", 32'(bus.state), 0);
        check_eq("ill_s0_flag", 32'(bus.illegal_op), 0);

        bus.op = 6'b001000;
`ifdef MIPS_CTRL_ADDI_EN
        tick();
        check_eq("addi_s1", 32'(bus.state), 1);
        check_eq("addi_s1_illegal", 32'(bus.illegal_op), 0);
        tick();
        check_eq("addi_s10", 32'(bus.state), 10);
        check_eq("addi_s10_alusrcb", 32'(bus.alusrcb), 2);
        tick();
        check_eq("addi_s11", 32'(bus.state), 11);
        check_eq("addi_s11_regdst", 32'(bus.regdst), 0);
        check_eq("addi_s11_regwrite", 32'(bus.regwrite), 1);
        tick();
        check_eq("addi_s0", 32'(bus.state), 0);
        // Reset while in ADDIEX
        tick();
        tick();
        check_eq("addi_rst_s10", 32'(bus.state), 10);
        reset = 1'b1;
        tick();
        check_eq("addi_rst_s0", 32'(bus.state), 0);
        check_eq("addi_rst_regwrite", 32'(bus.regwrite), 0);
        reset = 1'b0;
        #1;
`else
        tick();
        check_eq("addi_off_s1", 32'(bus.state), 1);
        check_eq("addi_off_illegal", 32'(bus.illegal_op), 1);
        tick();
        check_eq("addi_off_s0", 32'(bus.state), 0);
`endif

        // Reset during ALUWB: write strobe suppressed, back to FETCH
        bus.op = 6'b000000;
        tick();
        tick();
        tick();
        check_eq("mid_s7", 32'(bus.state), 7);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_regwrite", 32'(bus.regwrite), 0);
        tick();
        check_eq("mid_rst_s0", 32'(bus.state), 0);
        reset = 1'b0;
        #1;
        check_eq("mid_rel_irwrite", 32'(bus.irwrite), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
